// File: rtl/pool_pkg.sv
// Shared constants, sample type and signed max helper for the 2x2 max-pool stage.
package pool_pkg;

    localparam int POOL_DW    = 32;
    localparam int POOL_IMG_W = 26;
    localparam int POOL_IMG_H = 26;

    typedef logic signed [POOL_DW-1:0] pool_sample_t;

    // Wide enough for any DW up to 64, so one helper serves every instance width.
    typedef logic signed [63:0] pool_wide_t;

    typedef enum logic {
        EVEN_ROW = 1'b0,
        ODD_ROW  = 1'b1
    } pool_state_e;

    function automatic pool_wide_t smax(input pool_wide_t a, input pool_wide_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-width line buffer holding the horizontal maxima of the last even row.
module pool_line_buf #(
    parameter int DW    = 32,
    parameter int DEPTH = 13,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/max_pool2x2.sv
// Streaming 2x2 stride-2 max-pool behind conv1; no frame storage, one half-width line buffer.
// Define MAX_POOL_RELU_EN to clamp negative inputs to zero before pooling (fused ReLU).
module max_pool2x2
    import pool_pkg::*;
#(
    parameter int DW    = POOL_DW,
    parameter int IMG_W = POOL_IMG_W,
    parameter int IMG_H = POOL_IMG_H
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] din,
    input  logic                 din_valid,
    output logic signed [DW-1:0] dout,
    output logic                 dout_valid,
    output logic                 frame_done
);

    localparam int CW       = $clog2(IMG_W);
    localparam int RW       = $clog2(IMG_H);
    localparam int AW       = CW - 1;
    localparam int LB_DEPTH = IMG_W / 2;

    localparam logic [CW-1:0] COL_LAST     = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST     = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_WIN_LAST = CW'(2 * (IMG_W / 2) - 1);
    localparam logic [RW-1:0] ROW_WIN_LAST = RW'(2 * (IMG_H / 2) - 1);

    logic [CW-1:0]        col_q, col_d;
    logic [RW-1:0]        row_q, row_d;
    logic signed [DW-1:0] h_reg_q;
    logic signed [DW-1:0] dout_q;
    logic                 dout_valid_q;
    logic                 frame_done_q;

    logic signed [DW-1:0] din_eff;
    logic signed [DW-1:0] hmax;
    logic signed [DW-1:0] win_max;
    logic signed [DW-1:0] lb_rdata_s;
    logic [DW-1:0]        lb_rdata;
    logic                 lb_we;
    logic                 last_win;
    pool_state_e          state;

`ifdef MAX_POOL_RELU_EN
    assign din_eff = din[DW-1] ? '0 : din;
`else
    assign din_eff = din;
`endif

    assign state      = pool_state_e'(row_q[0]);
    assign lb_rdata_s = $signed(lb_rdata);
    assign hmax       = DW'(smax(pool_wide_t'(h_reg_q), pool_wide_t'(din_eff)));
    assign win_max    = DW'(smax(pool_wide_t'(lb_rdata_s), pool_wide_t'(hmax)));
    assign last_win   = (row_q == ROW_WIN_LAST) && (col_q == COL_WIN_LAST);

    // An odd trailing column has col[0]=0 and an odd trailing row is even, so neither is ever pooled.
    assign lb_we = din_valid && !rst && (state == EVEN_ROW) && col_q[0];

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (din_valid) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            h_reg_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            dout_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            if (din_valid && !col_q[0]) begin
                h_reg_q <= din_eff;
            end
            if (din_valid && col_q[0] && (state == ODD_ROW)) begin
                dout_q       <= win_max;
                dout_valid_q <= 1'b1;
                frame_done_q <= last_win;
            end
        end
    end

    pool_line_buf #(
        .DW    (DW),
        .DEPTH (LB_DEPTH),
        .AW    (AW)
    ) u_line_buf (
        .clk     (clk),
        .we_i    (lb_we),
        .waddr_i (col_q[CW-1:1]),
        .wdata_i (hmax),
        .raddr_i (col_q[CW-1:1]),
        .rdata_o (lb_rdata)
    );

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_max_pool2x2.sv
// Scoreboard bench for max_pool2x2: 26x26, 4x4 and 5x5 instances share din, one is enabled at a time.
`timescale 1ns/1ps
module tb_max_pool2x2;
    import pool_pkg::*;

    typedef struct packed {
        logic signed [31:0] val;
        logic               last;
        logic [31:0]        cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic signed [31:0] din;
    logic               din_valid;
    int                 sel;
    logic               v0, v1, v2;
    logic signed [31:0] dout0, dout1, dout2;
    logic               dv0, dv1, dv2, fd0, fd1, fd2;

    assign v0 = din_valid && (sel == 0);
    assign v1 = din_valid && (sel == 1);
    assign v2 = din_valid && (sel == 2);

    max_pool2x2 #(.DW(32), .IMG_W(26), .IMG_H(26)) u_main (
        .clk(clk), .rst(rst), .din(din), .din_valid(v0),
        .dout(dout0), .dout_valid(dv0), .frame_done(fd0));
    max_pool2x2 #(.DW(32), .IMG_W(4), .IMG_H(4)) u_r4 (
        .clk(clk), .rst(rst), .din(din), .din_valid(v1),
        .dout(dout1), .dout_valid(dv1), .frame_done(fd1));
    max_pool2x2 #(.DW(32), .IMG_W(5), .IMG_H(5)) u_r5 (
        .clk(clk), .rst(rst), .din(din), .din_valid(v2),
        .dout(dout2), .dout_valid(dv2), .frame_done(fd2));

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    pool_sample_t pix [0:675];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int qsize(input int id);
        case (id)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic push(input int id, input exp_t e);
        case (id)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic mon(input int id, input logic dv, input logic fd, input logic signed [31:0] d);
        exp_t e;
        if (dv !== 1'b1) begin
            chk($sformatf("idle_frame_done[%0d]", id), {31'b0, fd}, 32'd0);
        end else if (qsize(id) == 0) begin
            chk($sformatf("spurious_valid[%0d]", id), {31'b0, dv}, 32'd0);
        end else begin
            case (id)
                0:       e = q0.pop_front();
                1:       e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            chk($sformatf("dout[%0d]", id), d, e.val);
            chk($sformatf("frame_done[%0d]", id), {31'b0, fd}, {31'b0, e.last});
            chk($sformatf("latency_cycle[%0d]", id), cyc, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        mon(0, dv0, fd0, dout0);
        mon(1, dv1, fd1, dout1);
        mon(2, dv2, fd2, dout2);
    end

    function automatic logic signed [31:0] act(input logic signed [31:0] x);
`ifdef MAX_POOL_RELU_EN
        return (x < 0) ? 32'sd0 : x;
`else
        return x;
`endif
    endfunction

    function automatic logic signed [31:0] m2(input logic signed [31:0] a, input logic signed [31:0] b);
        return (a >= b) ? a : b;
    endfunction

    task automatic step(input logic signed [31:0] v, input logic vld);
        din       = v;
        din_valid = vld;
        @(posedge clk);
        #1;
    endtask

    // Software pooling: the expectation for a window is queued when its bottom-right pixel is driven.
    task automatic run_frame(input int id, input int w, input int h, input int n, input int gap, input int drain);
        int   r, c;
        exp_t e;
        for (int i = 0; i < n; i++) begin
            r = i / w;
            c = i % w;
            if (gap > 0 && $urandom_range(3, 0) == 0) repeat ($urandom_range(gap, 1)) step(0, 1'b0);
            if ((r % 2 == 1) && (c % 2 == 1) && (r < 2 * (h / 2)) && (c < 2 * (w / 2))) begin
                e.val  = m2(m2(act(pix[i-w-1]), act(pix[i-w])), m2(act(pix[i-1]), act(pix[i])));
                e.last = (r == 2 * (h / 2) - 1) && (c == 2 * (w / 2) - 1);
                e.cyc  = cyc + 1;
                push(id, e);
            end
            step(pix[i], 1'b1);
        end
        repeat (drain) step(0, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        sel       = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout0", dout0, 32'd0);
        chk("rst_dv0", {31'b0, dv0}, 32'd0);
        chk("rst_fd0", {31'b0, fd0}, 32'd0);
        chk("rst_dout1", dout1, 32'd0);
        chk("rst_dv1", {31'b0, dv1}, 32'd0);
        chk("rst_dout2", dout2, 32'd0);
        chk("rst_dv2", {31'b0, dv2}, 32'd0);
        rst = 1'b0;
        step(0, 1'b0);

        // 4x4 ramp: outputs 5, 7, 13, 15
        sel = 1;
        for (int i = 0; i < 16; i++) pix[i] = i;
        run_frame(1, 4, 4, 16, 0, 3);

        // 4x4 negative windows, one -3 per window at varying positions
        for (int i = 0; i < 16; i++) pix[i] = -8;
        pix[0]  = -3;
        pix[3]  = -3;
        pix[12] = -3;
        pix[10] = -3;
        run_frame(1, 4, 4, 16, 0, 3);

        // Extremes: {max, min, 0, -1} and an all-minimum window
        for (int i = 0; i < 16; i++) pix[i] = $urandom();
        pix[0] = 32'sh7FFFFFFF;
        pix[1] = 32'sh80000000;
        pix[4] = 32'sh00000000;
        pix[5] = -1;
        pix[2] = 32'sh80000000;
        pix[3] = 32'sh80000000;
        pix[6] = 32'sh80000000;
        pix[7] = 32'sh80000000;
        run_frame(1, 4, 4, 16, 0, 3);

        // 5x5 ramp: outputs 6, 8, 16, 18; column 4 and row 4 unpooled
        sel = 2;
        for (int i = 0; i < 25; i++) pix[i] = i;
        run_frame(2, 5, 5, 25, 0, 3);

        // Two full default frames, random data, first with idle gaps, no reset between
        sel = 0;
        for (int i = 0; i < 676; i++) pix[i] = $urandom();
        run_frame(0, 26, 26, 676, 3, 0);
        for (int i = 0; i < 676; i++) pix[i] = $urandom();
        run_frame(0, 26, 26, 676, 0, 3);

        // Reset after 30 samples, colliding with a valid sample, then a fresh frame
        for (int i = 0; i < 676; i++) pix[i] = $urandom();
        run_frame(0, 26, 26, 30, 0, 0);
        rst = 1'b1;
        step(32'sh7FFFFFFF, 1'b1);
        rst = 1'b0;
        chk("midrst_dout0", dout0, 32'd0);
        chk("midrst_dv0", {31'b0, dv0}, 32'd0);
        chk("midrst_fd0", {31'b0, fd0}, 32'd0);
        step(0, 1'b0);
        for (int i = 0; i < 676; i++) pix[i] = $urandom();
        run_frame(0, 26, 26, 676, 2, 5);

        chk("pending_q0", qsize(0), 32'd0);
        chk("pending_q1", qsize(1), 32'd0);
        chk("pending_q2", qsize(2), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/max_pool2x2.md
# max_pool2x2

Streaming 2×2 / stride-2 max-pooling stage placed directly downstream of the `conv1` convolution filter.
- Consumes the signed 32-bit feature-map samples `conv1` emits on `data_out` whenever `wdata_r` is high, in raster order.
- Produces a decimated feature map (26×26 → 13×13 by default) for the next layer.
- Holds one half-width line buffer; no frame storage.

## Interface

Parameters:
- `DW`, 32: sample width (signed, two's complement).
- `IMG_W`, 26: input columns per row.
- `IMG_H`, 26: input rows per frame.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `din`  in  DW  signed input sample (from `conv1.data_out`).
- `din_valid`  in  1  sample qualifier (from `conv1.wdata_r`).
- `dout`  out  DW  signed pooled sample.
- `dout_valid`  out  1  one-cycle qualifier for `dout`.
- `frame_done`  out  1  one-cycle pulse coincident with the last pooled output of a frame.

## Operation

- Counters: `col` (0..IMG_W-1) and `row` (0..IMG_H-1) advance only on `din_valid`.
  - `col` wraps to 0 and increments `row`.
  - `row` wraps to 0 after the last sample, so the next frame needs no reset.
- Two states, derived from `row[0]`: `EVEN_ROW` and `ODD_ROW`.
- Horizontal stage:
  - Even `col`: latch `din` into `h_reg`.
  - Odd `col`: `hmax = max(h_reg, din)`, using a signed compare.
- `EVEN_ROW`, odd `col`: write `hmax` to `line_buf[col>>1]`. Nothing is emitted.
- `ODD_ROW`, odd `col`: `dout <= max(line_buf[col>>1], hmax)` and `dout_valid <= 1`.
- Odd sizes:
  - If `IMG_W` is odd, the final column of each row is ignored: counted, never pooled.
  - If `IMG_H` is odd, the final row is counted and discarded.
- Widths: no arithmetic growth; `dout` is exactly DW bits. The compare is a full DW-bit signed compare. Equal values: either operand, same result.
- Gaps: idle cycles (`din_valid = 0`) anywhere are legal. State holds and outputs deassert.

## Timing

- Reset values:
  - `dout = 0`, `dout_valid = 0`, `frame_done = 0`.
  - `col = 0`, `row = 0`, `h_reg = 0`.
  - `line_buf` is not cleared; every entry is written before it is read.
- Latency: `dout_valid` asserts exactly 1 cycle after the `din_valid` cycle carrying the bottom-right pixel of a 2×2 window.
- Throughput: one input per cycle, sustained.
  - Outputs occur in bursts of IMG_W/2, on every second valid input of odd rows.
- `frame_done` asserts in the same cycle as the `dout_valid` for window (IMG_H/2-1, IMG_W/2-1).
- Line buffer read/write: the read of `line_buf[k]` on an odd row never coincides with a write to the same entry. Read-during-write behaviour is therefore don't-care.
- `rst` mid-frame:
  - Next cycle all counters are 0 and outputs are 0.
  - The partial frame is dropped; the next `din_valid` is treated as pixel (0,0).
- `rst` and `din_valid` in the same cycle: reset wins and the sample is discarded.

## Configuration

- `MAX_POOL_RELU_EN` defined:
  - Each incoming `din` is clamped to 0 when negative, before the horizontal stage.
  - `dout` is therefore always ≥ 0. This fuses the activation into the pooling stage.
- `MAX_POOL_RELU_EN` undefined:
  - Raw signed max.
  - An all-negative window outputs its least-negative value.

## Structure

- Package `pool_pkg`:
  - Default constants `POOL_DW = 32`, `POOL_IMG_W = 26`, `POOL_IMG_H = 26`.
  - Signed sample typedef `pool_sample_t`.
  - Function `smax(a, b)`.
- Sub-module `pool_line_buf`:
  - Depth IMG_W/2, width DW.
  - One write port and one asynchronous-read port.
  - Single clock, no reset.
- Top `max_pool2x2` contains the counters, `h_reg`, the compare logic and the output registers.

## Test plan

- Ramp, IMG_W=IMG_H=4, `din` = 0..15 continuous → `dout` = 5, 7, 13, 15 on four `dout_valid` pulses; `frame_done` with 15; each output 1 cycle after inputs 5, 7, 13, 15.
- Negative window, 4×4 all −8 except one −3 per window, without macro → every `dout` = −3; with `MAX_POOL_RELU_EN` → every `dout` = 0.
- Full default frame, 676 samples with random gaps of `din_valid` = 0, compared against a software 13×13 max-pool → 169 outputs match and `frame_done` fires once. A second frame back-to-back, without reset, also matches.
- Extremes, window {0x7FFFFFFF, 0x80000000, 0, −1} → `dout` = 0x7FFFFFFF; window {0x80000000 ×4} → 0x80000000 without macro.
- `rst` asserted after 30 samples of a 26×26 frame, followed by a fresh full frame → outputs 0 the cycle after reset, then 169 correct outputs with no stale window.
- Odd size, IMG_W=IMG_H=5, `din` = 0..24 → `dout` = 6, 8, 16, 18; column 4 and row 4 are never pooled; `frame_done` with 18.
